// File: rtl/ntt_pkg.sv
// Shared constants, FSM state encoding and twiddle index helper for the SDF NTT pipeline.
package ntt_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned LOG_N  = 3;
    localparam int unsigned DATA_W = 13;
    localparam int unsigned Q      = 7681;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    // ROM index feeding SDF stage 'stage' for sample counter value 'cnt'.
    function automatic logic [LOG_N-1:0] tw_idx(input int unsigned stage,
                                                input logic [LOG_N-1:0] cnt);
        return (LOG_N'(1) << stage) + (cnt >> (LOG_N - stage));
    endfunction

endpackage

// File: rtl/tw_bank_ram.sv
// Two-bank twiddle register file: one write port, LOG_N asynchronous read ports on a shared bank.
module tw_bank_ram
    import ntt_pkg::*;
(
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic                      wr_bank,
    input  logic [LOG_N-1:0]          wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_bank,
    input  logic [LOG_N*LOG_N-1:0]    rd_addr,
    output logic [LOG_N*DATA_W-1:0]   rd_data
);

    // Contents survive reset so a loaded table outlives a pipeline abort.
    logic [DATA_W-1:0] mem [2*N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    for (genvar s = 0; s < LOG_N; s++) begin : g_rd
        assign rd_data[s*DATA_W +: DATA_W] = mem[{rd_bank, rd_addr[s*LOG_N +: LOG_N]}];
    end

endmodule

// File: rtl/tw_factor_seq.sv
// Twiddle-factor sequencer: emits one twiddle per SDF stage for every accepted sample.
module tw_factor_seq
    import ntt_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_bank,
    input  logic [LOG_N-1:0]          wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      stop,
    input  logic                      in_valid,
    output logic [LOG_N*DATA_W-1:0]   tw_out,
    output logic                      tw_valid,
    output logic [LOG_N-1:0]          cnt_out,
    output logic                      frame_last,
    output logic                      busy,
    output logic                      err
);

    state_t                    state_q, state_d;
    logic [LOG_N-1:0]          cnt_q, cnt_d;
    logic                      mode_q, mode_d;
    logic [LOG_N*DATA_W-1:0]   tw_d;
    logic [LOG_N-1:0]          cnt_out_d;
    logic                      tw_valid_d, frame_last_d, busy_d, err_d;

    logic                      accept_c;
    logic                      cnt_last_c;
    logic                      wr_bad_c;
    logic [LOG_N*LOG_N-1:0]    rd_addr_c;
    logic [LOG_N*DATA_W-1:0]   rd_data_c;

    assign accept_c   = in_valid && (state_q != S_IDLE);
    assign cnt_last_c = (cnt_q == LOG_N'(N - 1));
    assign wr_bad_c   = wr_en && ((state_q != S_IDLE) || (wr_addr == '0) ||
                                  (wr_data >= DATA_W'(Q)));

    for (genvar s = 0; s < LOG_N; s++) begin : g_idx
        assign rd_addr_c[s*LOG_N +: LOG_N] = tw_idx(s, cnt_q);
    end

    tw_bank_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en && !wr_bad_c),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_bank (mode_q),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data_c)
    );

    // Next-state, counter and output-register inputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        err_d        = err || wr_bad_c;
        tw_valid_d   = accept_c;
        frame_last_d = accept_c && cnt_last_c;
        cnt_out_d    = accept_c ? cnt_q : cnt_out;
        tw_d         = accept_c ? rd_data_c : tw_out;

        if (accept_c) begin
            cnt_d = cnt_q + LOG_N'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // A stop on the frame's final sample has nothing left to drain.
                if (stop) begin
                    if (!in_valid && (cnt_q == '0)) begin
                        state_d = S_IDLE;
                    end else if (accept_c && cnt_last_c) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (accept_c && cnt_last_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            tw_out     <= '0;
            tw_valid   <= 1'b0;
            cnt_out    <= '0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            tw_out     <= tw_d;
            tw_valid   <= tw_valid_d;
            cnt_out    <= cnt_out_d;
            frame_last <= frame_last_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_tw_factor_seq.sv
// Directed scoreboard bench for tw_factor_seq (N=8, Q=7681).
module tb_tw_factor_seq;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        wr_bank;
    logic [2:0]  wr_addr;
    logic [12:0] wr_data;
    logic        start;
    logic        mode;
    logic        stop;
    logic        in_valid;
    logic [38:0] tw_out;
    logic        tw_valid;
    logic [2:0]  cnt_out;
    logic        frame_last;
    logic        busy;
    logic        err;

    tw_factor_seq dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .mode       (mode),
        .stop       (stop),
        .in_valid   (in_valid),
        .tw_out     (tw_out),
        .tw_valid   (tw_valid),
        .cnt_out    (cnt_out),
        .frame_last (frame_last),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [38:0] tw;
        logic [2:0]  cnt;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [12:0] rom_m [2][8];
    int          m_state = 0;
    int          m_cnt   = 0;
    int          m_mode  = 0;
    logic        m_err   = 1'b0;
    logic        exp_v   = 1'b0;
    logic [38:0] hold_tw  = '0;
    logic [2:0]  hold_cnt = '0;

    // Scenario-1 reference columns, written out directly
    logic [12:0] lit_s1 [8] = '{13'h785, 13'h785, 13'h785, 13'h785,
                                13'h1ab0, 13'h1ab0, 13'h1ab0, 13'h1ab0};
    logic [12:0] lit_s2 [8] = '{13'hd37, 13'hd37, 13'h6c0, 13'h6c0,
                                13'h1944, 13'h1944, 13'h20f, 13'h20f};
    logic [12:0] fwd_vals [7] = '{13'h1bba, 13'h785, 13'h1ab0, 13'hd37,
                                  13'h6c0, 13'h1944, 13'h20f};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] model_tw(input int bank, input int c);
        logic [38:0] r;
        r = '0;
        for (int s = 0; s < 3; s++) begin
            r[s*13 +: 13] = rom_m[bank][(1 << s) + c / (8 >> s)];
        end
        return r;
    endfunction

    // Advance the model with the current inputs, clock once, then check every output.
    task automatic tick();
        logic acc;
        exp_t e;
        acc   = in_valid && (m_state != 0) && !rst;
        exp_v = acc;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_mode = 0; m_err = 1'b0;
            sb_q.delete();
            hold_tw = '0; hold_cnt = '0;
        end else begin
            if (acc) begin
                e.tw   = model_tw(m_mode, m_cnt);
                e.cnt  = 3'(m_cnt);
                e.last = (m_cnt == 7);
                sb_q.push_back(e);
            end
            if (wr_en) begin
                if (m_state != 0 || wr_addr == 3'd0 || wr_data >= 13'd7681) m_err = 1'b1;
                else rom_m[wr_bank][wr_addr] = wr_data;
            end
            case (m_state)
                0: if (start) begin m_state = 1; m_mode = int'(mode); m_cnt = 0; end
                1: if (stop) begin
                       if (!in_valid && m_cnt == 0) m_state = 0;
                       else if (acc && m_cnt == 7) m_state = 0;
                       else m_state = 2;
                   end
                default: if (acc && m_cnt == 7) m_state = 0;
            endcase
            if (acc) m_cnt = (m_cnt + 1) % 8;
        end

        @(posedge clk);
        #1;
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("err", 64'(err), 64'(m_err));
        chk("tw_valid", 64'(tw_valid), 64'(exp_v));
        if (exp_v) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("tw_out", 64'(tw_out), 64'(e.tw));
                chk("cnt_out", 64'(cnt_out), 64'(e.cnt));
                chk("frame_last", 64'(frame_last), 64'(e.last));
                hold_tw  = e.tw;
                hold_cnt = e.cnt;
            end
        end else begin
            chk("frame_last_idle", 64'(frame_last), 64'(0));
            chk("tw_out_hold", 64'(tw_out), 64'(hold_tw));
            chk("cnt_out_hold", 64'(cnt_out), 64'(hold_cnt));
        end

        rst = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0; in_valid = 1'b0;
    endtask

    task automatic wr(input logic bank, input logic [2:0] addr, input logic [12:0] data);
        wr_en = 1'b1; wr_bank = bank; wr_addr = addr; wr_data = data;
        tick();
    endtask

    task automatic go(input logic m);
        start = 1'b1; mode = m;
        tick();
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            tick();
        end
    endtask

    // One back-to-back frame compared against the scenario-1 table.
    task automatic lit_frame();
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            tick();
            chk("lit_tw", 64'(tw_out), 64'({lit_s2[c], lit_s1[c], 13'h1bba}));
            chk("lit_last", 64'(frame_last), 64'(c == 7));
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_bank = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; mode = 1'b0; stop = 1'b0; in_valid = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 8; a++) rom_m[b][a] = '0;

        // Reset state
        tick();
        rst = 1'b1;
        tick();
        chk("rst_tw_out", 64'(tw_out), 64'(0));

        // 1: forward load, write-then-start, one frame
        for (int a = 1; a < 8; a++) wr(1'b0, 3'(a), fwd_vals[a-1]);
        go(1'b0);
        lit_frame();
        stop = 1'b1;
        tick();

        // 2: inverse bank, mode change mid-run ignored
        for (int a = 1; a < 8; a++) wr(1'b1, 3'(a), 13'(100 + 37 * a));
        go(1'b1);
        samples(4);
        chk("inv_stage0", 64'(tw_out[12:0]), 64'(13'd137));
        mode = 1'b0;
        samples(4);
        chk("inv_stage2_last", 64'(tw_out[38:26]), 64'(13'd359));
        stop = 1'b1;
        tick();

        // 3: gapped input across two frames, then wrap back-to-back
        go(1'b0);
        for (int i = 0; i < 48; i++) begin
            in_valid = (i % 3 == 0);
            tick();
        end
        samples(10);
        stop = 1'b1;
        tick();
        samples(6);
        chk("s3_idle", 64'(busy), 64'(0));

        // 4: stop at cnt 3, frame completes, later in_valid ignored
        go(1'b0);
        samples(3);
        stop = 1'b1;
        tick();
        samples(5);
        chk("s4_last", 64'(frame_last), 64'(1));
        chk("s4_busy", 64'(busy), 64'(0));
        samples(1);
        chk("s4_ignored", 64'(tw_valid), 64'(0));

        // 5: illegal writes each set err; table untouched
        go(1'b0);
        wr(1'b0, 3'd1, 13'd5);
        stop = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        wr(1'b0, 3'd2, 13'h1e01);
        rst = 1'b1;
        tick();
        chk("err_cleared", 64'(err), 64'(0));
        wr(1'b0, 3'd0, 13'd7);
        rst = 1'b1;
        tick();
        go(1'b0);
        lit_frame();
        stop = 1'b1;
        tick();

        // 6: reset mid-frame, ROM retained, restart matches scenario 1
        go(1'b0);
        samples(5);
        rst = 1'b1; in_valid = 1'b1;
        tick();
        chk("s6_tw_zero", 64'(tw_out), 64'(0));
        chk("s6_cnt_zero", 64'(cnt_out), 64'(0));
        go(1'b0);
        lit_frame();
        stop = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
